// File: rtl/uart_cmd_proc_if.sv
// Command/register/response signal bundle between uart_cmd_proc and its surroundings.
// master: the command processor. slave: UART front end plus register file.
interface uart_cmd_proc_if;
  logic [31:0] cmd_word;
  logic        cmd_valid;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        reg_rd_valid;
  logic        tx_full;
  logic [31:0] resp_word;
  logic        resp_en;
  logic        busy;
  logic [7:0]  drop_cnt;

  modport master (
    input  cmd_word, cmd_valid, reg_rdata, reg_rd_valid, tx_full,
    output reg_wr_en, reg_rd_en, reg_addr, reg_wdata, resp_word, resp_en, busy, drop_cnt
  );

  modport slave (
    output cmd_word, cmd_valid, reg_rdata, reg_rd_valid, tx_full,
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wdata, resp_word, resp_en, busy, drop_cnt
  );
endinterface

// File: rtl/uart_cmd_proc.sv
// UART command processor: turns 32-bit command words into single register bus
// transactions and answers each accepted command with exactly one response word.
module uart_cmd_proc #(
  parameter int RD_TIMEOUT = 255
) (
  input  logic            sys_clk,
  input  logic            rst,
  uart_cmd_proc_if.master bus
);

  localparam logic [7:0]  OP_WRITE   = 8'h57;
  localparam logic [7:0]  OP_READ    = 8'h52;
  localparam logic [7:0]  RSP_WR_ACK = 8'h4B;
  localparam logic [7:0]  RSP_RD_DAT = 8'h44;
  localparam logic [7:0]  RSP_ERROR  = 8'h45;
  localparam logic [15:0] ERR_BAD_OP = 16'h0001;
  localparam logic [15:0] ERR_RD_TMO = 16'h0002;
  localparam logic [15:0] TMO_LAST   = 16'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DECODE, RD_WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  op;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [31:0] resp;
  logic [31:0] resp_nxt;
  logic        resp_load;
  logic [15:0] tmo_cnt;
  logic        tmo_clr;
  logic        tmo_inc;
  logic [7:0]  drops;
  logic        wr_en;
  logic        rd_en;
  logic        resp_pulse;

  // Saturating 8-bit increment: sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  // State register and command/response/counter registers.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= 8'h00;
      addr    <= 8'h00;
      wdata   <= 16'h0000;
      resp    <= 32'h0000_0000;
      tmo_cnt <= 16'h0000;
      drops   <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.cmd_valid) begin
        op    <= bus.cmd_word[31:24];
        addr  <= bus.cmd_word[23:16];
        wdata <= bus.cmd_word[15:0];
      end
      if (resp_load) resp <= resp_nxt;
      if (tmo_clr)      tmo_cnt <= 16'h0000;
      else if (tmo_inc) tmo_cnt <= tmo_cnt + 16'd1;
      // Any command arriving outside IDLE, including the response cycle, is lost.
      if (state != IDLE && bus.cmd_valid) drops <= sat_inc8(drops);
    end
  end

  // Next-state decode, bus strobes and response formation.
  always_comb begin
    state_nxt  = state;
    resp_nxt   = resp;
    resp_load  = 1'b0;
    tmo_clr    = 1'b0;
    tmo_inc    = 1'b0;
    wr_en      = 1'b0;
    rd_en      = 1'b0;
    resp_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (op == OP_WRITE) begin
          wr_en     = 1'b1;
          resp_nxt  = {RSP_WR_ACK, addr, wdata};
          resp_load = 1'b1;
          state_nxt = RESP;
        end else if (op == OP_READ) begin
          rd_en     = 1'b1;
          tmo_clr   = 1'b1;
          state_nxt = RD_WAIT;
        end else begin
          resp_nxt  = {RSP_ERROR, addr, ERR_BAD_OP};
          resp_load = 1'b1;
          state_nxt = RESP;
        end
      end
      RD_WAIT: begin
        // Valid data wins even on the last allowed wait cycle.
        if (bus.reg_rd_valid) begin
          resp_nxt  = {RSP_RD_DAT, addr, bus.reg_rdata};
          resp_load = 1'b1;
          state_nxt = RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          resp_nxt  = {RSP_ERROR, addr, ERR_RD_TMO};
          resp_load = 1'b1;
          state_nxt = RESP;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      RESP: begin
        // Hold the response indefinitely while the transmit FIFO is full.
        if (!bus.tx_full) begin
          resp_pulse = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.reg_wr_en = wr_en;
  assign bus.reg_rd_en = rd_en;
  assign bus.reg_addr  = addr;
  assign bus.reg_wdata = wdata;
  assign bus.resp_word = resp;
  assign bus.resp_en   = resp_pulse;
  assign bus.busy      = (state != IDLE);
  assign bus.drop_cnt  = drops;

endmodule

// File: tb/tb_uart_cmd_proc.sv
// Testbench for uart_cmd_proc: vector table for single transactions, hand-written
// sequences for timeout, backpressure, drop saturation and reset abort; responses
// are matched against a queue of expected words.
module tb_uart_cmd_proc;

  localparam int TMO = 4;

  logic sys_clk;
  logic rst;
  uart_cmd_proc_if bus ();

  uart_cmd_proc #(.RD_TIMEOUT(TMO)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [31:0] cmd;
    int          rd_lat;
    logic [15:0] rdata;
    logic [31:0] resp;
    logic        exp_wr;
    logic        exp_rd;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] exp_q[$];
  int          checks;
  int          errors;
  int          resp_seen;
  int          resp_pushed;
  int          wr_seen;
  int          rd_seen;
  int          wr_exp;
  int          rd_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_q.push_back(v.resp);
    resp_pushed++;
    if (v.exp_wr) wr_exp++;
    if (v.exp_rd) rd_exp++;
    next_cycle();
    bus.cmd_word  = v.cmd;
    bus.cmd_valid = 1'b1;
    next_cycle();
    bus.cmd_valid = 1'b0;
    @(negedge sys_clk);
    chk("dec_wr_en", 32'(bus.reg_wr_en), 32'(v.exp_wr));
    chk("dec_rd_en", 32'(bus.reg_rd_en), 32'(v.exp_rd));
    chk("dec_addr", 32'(bus.reg_addr), 32'(v.cmd[23:16]));
    chk("dec_busy", 32'(bus.busy), 32'd1);
    if (v.exp_wr) chk("dec_wdata", 32'(bus.reg_wdata), 32'(v.cmd[15:0]));
    next_cycle();
    if (v.exp_rd) begin
      for (int c = 2; c < v.rd_lat; c++) next_cycle();
      bus.reg_rdata    = v.rdata;
      bus.reg_rd_valid = 1'b1;
      next_cycle();
      bus.reg_rd_valid = 1'b0;
      bus.reg_rdata    = 16'h0000;
    end
    @(negedge sys_clk);
    chk("resp_latency", 32'(bus.resp_en), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("idle_reached", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; resp_seen = 0; resp_pushed = 0;
    wr_seen = 0; rd_seen = 0; wr_exp = 0; rd_exp = 0;
    vecs[0] = '{32'h5710BEEF, 0, 16'h0000, 32'h4B10BEEF, 1'b1, 1'b0};
    vecs[1] = '{32'h52220000, 3, 16'h1234, 32'h44221234, 1'b0, 1'b1};
    vecs[2] = '{32'h99050000, 0, 16'h0000, 32'h45050001, 1'b0, 1'b0};
    vecs[3] = '{32'h527F0000, 2, 16'hABCD, 32'h447FABCD, 1'b0, 1'b1};
    vecs[4] = '{32'h57FF0001, 0, 16'h0000, 32'h4BFF0001, 1'b1, 1'b0};
    vecs[5] = '{32'h52010000, 5, 16'h5A5A, 32'h44015A5A, 1'b0, 1'b1};
    vecs[6] = '{32'h00000000, 0, 16'h0000, 32'h45000001, 1'b0, 1'b0};
    vecs[7] = '{32'h52AAFFFF, 4, 16'h0000, 32'h44AA0000, 1'b0, 1'b1};
    vecs[8] = '{32'h57000000, 0, 16'h0000, 32'h4B000000, 1'b1, 1'b0};

    rst = 1'b1;
    bus.cmd_word = 32'h0; bus.cmd_valid = 1'b0;
    bus.reg_rdata = 16'h0; bus.reg_rd_valid = 1'b0; bus.tx_full = 1'b0;

    // Response scoreboard and strobe counters.
    fork
      forever begin
        @(negedge sys_clk);
        if (!rst) begin
          if (bus.reg_wr_en) wr_seen++;
          if (bus.reg_rd_en) rd_seen++;
          if (bus.resp_en) begin
            resp_seen++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL resp_unexpected actual=%h required=none", bus.resp_word);
            end else begin
              chk("resp_word", bus.resp_word, exp_q.pop_front());
            end
          end
        end
      end
    join_none

    repeat (3) next_cycle();
    @(negedge sys_clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_resp_en", 32'(bus.resp_en), 32'd0);
    chk("rst_resp_word", bus.resp_word, 32'd0);
    chk("rst_addr", 32'(bus.reg_addr), 32'd0);
    chk("rst_wdata", 32'(bus.reg_wdata), 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    chk("rst_strobes", 32'({bus.reg_wr_en, bus.reg_rd_en}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Read timeout: RD_TIMEOUT wait cycles, error response at N+2+RD_TIMEOUT.
    begin
      int lat;
      exp_q.push_back(32'h45330002);
      resp_pushed++; rd_exp++;
      next_cycle();
      bus.cmd_word = 32'h52330000; bus.cmd_valid = 1'b1;
      next_cycle();
      bus.cmd_valid = 1'b0;
      lat = 1;
      @(negedge sys_clk);
      while (bus.resp_en !== 1'b1 && lat < 30) begin
        @(negedge sys_clk);
        lat++;
      end
      chk("tmo_latency", 32'(lat), 32'(TMO + 2));
      wait_idle(5);
    end

    // Backpressure: response held while tx_full, two drops during hold, one in pulse cycle.
    exp_q.push_back(32'h4B10BEEF);
    resp_pushed++; wr_exp++;
    next_cycle();
    bus.tx_full = 1'b1;
    bus.cmd_word = 32'h5710BEEF; bus.cmd_valid = 1'b1;
    next_cycle();
    bus.cmd_valid = 1'b0;
    next_cycle();
    bus.cmd_word = 32'h57201111;
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = (i == 2 || i == 5);
      @(negedge sys_clk);
      chk("hold_resp_en", 32'(bus.resp_en), 32'd0);
      chk("hold_resp_word", bus.resp_word, 32'h4B10BEEF);
      next_cycle();
    end
    bus.tx_full = 1'b0;
    bus.cmd_valid = 1'b1;
    @(negedge sys_clk);
    chk("release_resp_en", 32'(bus.resp_en), 32'd1);
    next_cycle();
    bus.cmd_valid = 1'b0;
    @(negedge sys_clk);
    chk("drop_cnt_3", 32'(bus.drop_cnt), 32'd3);
    chk("release_idle", 32'(bus.busy), 32'd0);

    // Drop counter saturation.
    exp_q.push_back(32'h4B0C0C0C);
    resp_pushed++; wr_exp++;
    next_cycle();
    bus.tx_full = 1'b1;
    bus.cmd_word = 32'h570C0C0C; bus.cmd_valid = 1'b1;
    next_cycle();
    bus.cmd_word = 32'h99000000;
    bus.cmd_valid = 1'b0;
    next_cycle();
    bus.cmd_valid = 1'b1;
    repeat (300) next_cycle();
    bus.cmd_valid = 1'b0;
    @(negedge sys_clk);
    chk("drop_sat", 32'(bus.drop_cnt), 32'hFF);
    next_cycle();
    bus.tx_full = 1'b0;
    wait_idle(5);
    chk("drop_sat_hold", 32'(bus.drop_cnt), 32'hFF);

    // Reset while waiting for read data aborts the read with no response.
    rd_exp++;
    next_cycle();
    bus.cmd_word = 32'h52440000; bus.cmd_valid = 1'b1;
    next_cycle();
    bus.cmd_valid = 1'b0;
    next_cycle();
    @(negedge sys_clk);
    chk("rdwait_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge sys_clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_drop", 32'(bus.drop_cnt), 32'd0);
    chk("abort_resp_word", bus.resp_word, 32'd0);
    next_cycle();
    bus.reg_rdata = 16'hDEAD; bus.reg_rd_valid = 1'b1;
    next_cycle();
    bus.reg_rd_valid = 1'b0;
    repeat (8) next_cycle();
    @(negedge sys_clk);
    chk("stray_valid_busy", 32'(bus.busy), 32'd0);
    run_vec(vecs[0]);
    run_vec(vecs[1]);

    repeat (3) next_cycle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("resp_count", 32'(resp_seen), 32'(resp_pushed));
    chk("wr_strobe_count", 32'(wr_seen), 32'(wr_exp));
    chk("rd_strobe_count", 32'(rd_seen), 32'(rd_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
